// File: rtl/payload_scan_ctrl.sv
// payload_scan_ctrl: per-packet sequencer for the payload engine array (clear, scan, flush, report).
// Define PAYLOAD_SCAN_CTRL_STATS_EN to build the packet/match/truncation statistics counters.
module payload_scan_ctrl #(
    parameter int unsigned NUM_ENGINES  = 64,
    parameter int unsigned MAX_BYTES    = 1500,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             s_tdata,
    input  logic                   s_tvalid,
    input  logic                   s_tlast,
    output logic                   s_tready,
    output logic                   eng_sod,
    output logic                   eng_en,
    output logic [7:0]             eng_char,
    output logic                   eng_char_vld,
    input  logic [NUM_ENGINES-1:0] eng_match,
    output logic [NUM_ENGINES-1:0] m_match,
    output logic [15:0]            m_len,
    output logic                   m_trunc,
    output logic                   m_valid,
    input  logic                   m_ready
`ifdef PAYLOAD_SCAN_CTRL_STATS_EN
    ,
    output logic [31:0]            stat_pkts,
    output logic [31:0]            stat_match_pkts,
    output logic [31:0]            stat_trunc_pkts
`endif
);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StScan,
        StDrain,
        StFlush,
        StReport
    } state_e;

    localparam logic [15:0] MaxLen    = 16'(MAX_BYTES);
    localparam logic [3:0]  FlushLast = 4'(FLUSH_CYCLES);

    state_e                 state_q;
    logic [15:0]            len_q;
    logic [15:0]            len_inc;
    logic                   trunc_q;
    logic [3:0]             flush_cnt_q;
    logic                   sod_q;
    logic                   en_q;
    logic                   vld_q;
    logic [7:0]             char_q;
    logic [NUM_ENGINES-1:0] match_q;
    logic [15:0]            m_len_q;
    logic                   m_trunc_q;
    logic                   m_valid_q;

    // Ready is a pure decode of the registered state, so it never depends on s_tvalid.
    assign s_tready = (state_q == StScan) || (state_q == StDrain);
    assign len_inc  = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            len_q       <= '0;
            trunc_q     <= 1'b0;
            flush_cnt_q <= '0;
            sod_q       <= 1'b1;
            en_q        <= 1'b0;
            vld_q       <= 1'b0;
            char_q      <= '0;
            match_q     <= '0;
            m_len_q     <= '0;
            m_trunc_q   <= 1'b0;
            m_valid_q   <= 1'b0;
        end else begin
            sod_q <= 1'b0;
            en_q  <= 1'b0;
            vld_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (s_tvalid) begin
                        state_q <= StClear;
                        sod_q   <= 1'b1;
                        len_q   <= '0;
                        trunc_q <= 1'b0;
                    end
                end
                StClear: begin
                    state_q <= StScan;
                end
                StScan: begin
                    if (s_tvalid) begin
                        en_q   <= 1'b1;
                        vld_q  <= 1'b1;
                        char_q <= s_tdata;
                        len_q  <= len_inc;
                        if (s_tlast) begin
                            state_q     <= StFlush;
                            flush_cnt_q <= '0;
                        end else if (len_inc == MaxLen) begin
                            // More bytes must follow, so the packet is already known to overflow.
                            state_q <= StDrain;
                            trunc_q <= 1'b1;
                        end
                    end
                end
                StDrain: begin
                    if (s_tvalid) begin
                        len_q <= len_inc;
                        if (s_tlast) begin
                            state_q     <= StFlush;
                            flush_cnt_q <= '0;
                        end
                    end
                end
                StFlush: begin
                    // One extra cycle after the last pulse lets the engines settle before sampling.
                    if (flush_cnt_q == FlushLast) begin
                        state_q <= StReport;
                    end else begin
                        en_q        <= 1'b1;
                        flush_cnt_q <= flush_cnt_q + 4'd1;
                    end
                end
                StReport: begin
                    if (!m_valid_q) begin
                        match_q   <= eng_match;
                        m_len_q   <= len_q;
                        m_trunc_q <= trunc_q;
                        m_valid_q <= 1'b1;
                    end else if (m_ready) begin
                        m_valid_q <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign eng_sod      = sod_q;
    assign eng_en       = en_q;
    assign eng_char     = char_q;
    assign eng_char_vld = vld_q;
    assign m_match      = match_q;
    assign m_len        = m_len_q;
    assign m_trunc      = m_trunc_q;
    assign m_valid      = m_valid_q;

`ifdef PAYLOAD_SCAN_CTRL_STATS_EN
    logic [31:0] stat_pkts_q;
    logic [31:0] stat_match_q;
    logic [31:0] stat_trunc_q;
    logic        res_hs;

    assign res_hs = m_valid_q && m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_pkts_q  <= '0;
            stat_match_q <= '0;
            stat_trunc_q <= '0;
        end else if (res_hs) begin
            stat_pkts_q <= stat_pkts_q + 32'd1;
            if (|match_q) begin
                stat_match_q <= stat_match_q + 32'd1;
            end
            if (m_trunc_q) begin
                stat_trunc_q <= stat_trunc_q + 32'd1;
            end
        end
    end

    assign stat_pkts       = stat_pkts_q;
    assign stat_match_pkts = stat_match_q;
    assign stat_trunc_pkts = stat_trunc_q;
`endif

endmodule

// File: tb/tb_payload_scan_ctrl.sv
// Self-checking bench for payload_scan_ctrl: random packets against a reference engine model.
// A small engine stub folds scanned bytes into a match vector so sampling time is observable.
module tb_payload_scan_ctrl;

    localparam int unsigned NE   = 64;
    localparam int unsigned MAXB = 6;
    localparam int unsigned FLC  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    s_tdata;
    logic          s_tvalid;
    logic          s_tlast;
    logic          s_tready;
    logic          eng_sod;
    logic          eng_en;
    logic [7:0]    eng_char;
    logic          eng_char_vld;
    logic [NE-1:0] eng_match;
    logic [NE-1:0] m_match;
    logic [15:0]   m_len;
    logic          m_trunc;
    logic          m_valid;
    logic          m_ready;
`ifdef PAYLOAD_SCAN_CTRL_STATS_EN
    logic [31:0]   stat_pkts;
    logic [31:0]   stat_match_pkts;
    logic [31:0]   stat_trunc_pkts;
`endif

    always #5 clk = ~clk;

    payload_scan_ctrl #(
        .NUM_ENGINES (NE),
        .MAX_BYTES   (MAXB),
        .FLUSH_CYCLES(FLC)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .s_tdata     (s_tdata),
        .s_tvalid    (s_tvalid),
        .s_tlast     (s_tlast),
        .s_tready    (s_tready),
        .eng_sod     (eng_sod),
        .eng_en      (eng_en),
        .eng_char    (eng_char),
        .eng_char_vld(eng_char_vld),
        .eng_match   (eng_match),
        .m_match     (m_match),
        .m_len       (m_len),
        .m_trunc     (m_trunc),
        .m_valid     (m_valid),
        .m_ready     (m_ready)
`ifdef PAYLOAD_SCAN_CTRL_STATS_EN
        ,
        .stat_pkts      (stat_pkts),
        .stat_match_pkts(stat_match_pkts),
        .stat_trunc_pkts(stat_trunc_pkts)
`endif
    );

    function automatic logic [63:0] mix(input logic [7:0] c);
        return {8{c}} ^ (64'd1 << c[5:0]);
    endfunction

    // Engine stub: cleared by eng_sod, rotates on every enable, folds in the byte when valid.
    logic [63:0] acc;
    always @(posedge clk) begin
        if (eng_sod === 1'b1) acc <= '0;
        else if (eng_en === 1'b1) acc <= {acc[62:0], acc[63]} ^ (eng_char_vld ? mix(eng_char) : 64'd0);
    end
    assign eng_match = acc;

    int sod_cnt = 0;
    int scan_cnt = 0;
    int flush_cnt = 0;
    always @(negedge clk) begin
        if (eng_sod === 1'b1) sod_cnt <= sod_cnt + 1;
        if (eng_en === 1'b1 && eng_char_vld === 1'b1) scan_cnt <= scan_cnt + 1;
        if (eng_en === 1'b1 && eng_char_vld === 1'b0) flush_cnt <= flush_cnt + 1;
    end

    logic [7:0] pkt[$];
    int n_checks = 0;
    int n_pass = 0;
    int snap_sod, snap_scan, snap_flush;
    bit next_pending = 1'b0;
    int exp_pkts = 0;
    int exp_match = 0;
    int exp_trunc = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic logic [63:0] model_match(input int n);
        logic [63:0] a;
        int scanned;
        a = '0;
        scanned = (n < int'(MAXB)) ? n : int'(MAXB);
        for (int i = 0; i < scanned; i++) a = {a[62:0], a[63]} ^ mix(pkt[i]);
        for (int i = 0; i < int'(FLC); i++) a = {a[62:0], a[63]};
        return a;
    endfunction

    task automatic fill_random(input int n);
        pkt.delete();
        for (int i = 0; i < n; i++) pkt.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic take_snap();
        snap_sod   = sod_cnt;
        snap_scan  = scan_cnt;
        snap_flush = flush_cnt;
    endtask

    // Called and returns at posedge+1; stops after stop_at accepted bytes.
    task automatic send_pkt(input int n, input bit gaps, input int stop_at);
        int idx;
        int guard;
        bit hs;
        idx = 0;
        guard = 0;
        while (idx < stop_at && guard < 2000) begin
            if (gaps && $urandom_range(0, 1) == 0) begin
                s_tvalid = 1'b0;
            end else begin
                s_tvalid = 1'b1;
                s_tdata  = pkt[idx];
                s_tlast  = (idx == n - 1);
            end
            hs = s_tvalid && s_tready;
            @(posedge clk);
            #1;
            if (hs) idx++;
            guard++;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        check_eq("bytes_sent", 64'(idx), 64'(stop_at));
    endtask

    task automatic wait_result(input int n, input int hold, input bit pend_next);
        int guard;
        int scanned;
        logic [63:0] em;
        guard = 0;
        while (m_valid !== 1'b1 && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check_eq("result_valid", 64'(m_valid), 64'd1);
        if (m_valid === 1'b1) begin
            em = model_match(n);
            scanned = (n < int'(MAXB)) ? n : int'(MAXB);
            check_eq("m_match", m_match, em);
            check_eq("m_len", 64'(m_len), 64'(n));
            check_eq("m_trunc", 64'(m_trunc), 64'(n > int'(MAXB)));
            check_eq("scan_en", 64'(scan_cnt - snap_scan), 64'(scanned));
            check_eq("flush_en", 64'(flush_cnt - snap_flush), 64'(FLC));
            check_eq("sod", 64'(sod_cnt - snap_sod), 64'd1);
            if (pend_next) s_tvalid = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                check_eq("hold_ctl", 64'({m_valid, s_tready, m_trunc}),
                         64'({1'b1, 1'b0, n > int'(MAXB)}));
                check_eq("hold_match", m_match, em);
                check_eq("hold_len", 64'(m_len), 64'(n));
            end
            m_ready = 1'b1;
            @(posedge clk);
            #1;
            m_ready = 1'b0;
            check_eq("valid_drop", 64'(m_valid), 64'd0);
            exp_pkts++;
            if (em != 0) exp_match++;
            if (n > int'(MAXB)) exp_trunc++;
            take_snap();
            next_pending = pend_next;
            if (pend_next) begin
                check_eq("sod_1cyc", 64'(eng_sod), 64'd0);
                @(posedge clk);
                #1;
                check_eq("sod_2cyc", 64'(eng_sod), 64'd1);
                check_eq("ready_clear", 64'(s_tready), 64'd0);
            end
        end
    endtask

    task automatic run_pkt(input int n, input bit gaps, input int hold, input bit pend_next);
        if (!next_pending) take_snap();
        send_pkt(n, gaps, n);
        wait_result(n, hold, pend_next);
    endtask

    initial begin
        int vcnt;
        rst      = 1'b1;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tlast  = 1'b0;
        m_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("rst_sod", 64'(eng_sod), 64'd1);
        check_eq("rst_ctl", 64'({s_tready, eng_en, eng_char_vld, m_valid, m_trunc}), 64'd0);
        check_eq("rst_len", 64'(m_len), 64'd0);
        check_eq("rst_match", m_match, 64'd0);
        check_eq("rst_char", 64'(eng_char), 64'd0);
        @(posedge clk);
        #1;
        check_eq("sod_release", 64'(eng_sod), 64'd0);

        // "HTTP/" then tlast.
        pkt.delete();
        pkt.push_back(8'h48);
        pkt.push_back(8'h54);
        pkt.push_back(8'h54);
        pkt.push_back(8'h50);
        pkt.push_back(8'h2F);
        run_pkt(5, 1'b0, 0, 1'b0);

        fill_random(10);
        run_pkt(10, 1'b0, 0, 1'b0);
        fill_random(int'(MAXB));
        run_pkt(int'(MAXB), 1'b0, 0, 1'b0);
        fill_random(int'(MAXB) + 1);
        run_pkt(int'(MAXB) + 1, 1'b0, 0, 1'b0);
        fill_random(1);
        run_pkt(1, 1'b0, 0, 1'b0);

        // Long backpressure with the next packet already waiting.
        fill_random(4);
        run_pkt(4, 1'b0, 20, 1'b1);
        fill_random(3);
        run_pkt(3, 1'b0, 0, 1'b0);

        for (int k = 0; k < 8; k++) begin
            int n;
            n = int'($urandom_range(1, 12));
            fill_random(n);
            run_pkt(n, 1'b1, int'($urandom_range(0, 3)), 1'b0);
        end

        // Reset in the middle of an 8-byte packet.
        fill_random(8);
        take_snap();
        send_pkt(8, 1'b0, 3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("midrst_sod", 64'(eng_sod), 64'd1);
        check_eq("midrst_ctl", 64'({s_tready, eng_en, m_valid}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("midrst_sod_after", 64'(eng_sod), 64'd1);
        vcnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (m_valid !== 1'b0) vcnt++;
        end
        check_eq("midrst_no_valid", 64'(vcnt), 64'd0);
        exp_pkts = 0;
        exp_match = 0;
        exp_trunc = 0;
        next_pending = 1'b0;
        fill_random(1);
        run_pkt(1, 1'b0, 0, 1'b0);

`ifdef PAYLOAD_SCAN_CTRL_STATS_EN
        check_eq("stat_pkts", 64'(stat_pkts), 64'(exp_pkts));
        check_eq("stat_match", 64'(stat_match_pkts), 64'(exp_match));
        check_eq("stat_trunc", 64'(stat_trunc_pkts), 64'(exp_trunc));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
